// File: rtl/nios_mul_pkg.sv
// nios_mul_pkg: shared FSM states and datapath widths for the sequential multiplier
package nios_mul_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, RESP} state_t;
  localparam int HW = 16;
  localparam int W  = 32;
  localparam int MW = 33;
endpackage

// File: rtl/nios_mul_combine.sv
// nios_mul_combine: folds cell partial products into the low and high result words
module nios_mul_combine
  import nios_mul_pkg::*;
(
  input  logic [W-1:0] p1,
  input  logic [W-1:0] p2,
  input  logic [W-1:0] p3,
  input  logic [W-1:0] sp1,
  input  logic [W-1:0] sp2,
  input  logic [W-1:0] sp3,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);
  logic [W-1:0]  mid_lo;
  logic [MW-1:0] mid;
  // low word from live partials; high word uses the live hh (p1) plus stored low-pass partials
  always_comb begin
    mid_lo = p2 + p3;
    lo     = p1 + (mid_lo << HW);
    mid    = MW'(sp2) + MW'(sp3);
    hi     = p1 + W'(({mid, {HW{1'b0}}} + (MW+HW)'(sp1)) >> W);
  end
endmodule

// File: rtl/nios_mul_seq.sv
// nios_mul_seq: multi-pass multiply sequencer around an external 16x16 cell; NIOS_MUL_SEQ_HI_EN enables high-word results
module nios_mul_seq
  import nios_mul_pkg::*;
#(
  parameter int CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        req_hi,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data
);
  localparam int CW = CELL_LATENCY > 1 ? $clog2(CELL_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(CELL_LATENCY - 1);
`ifdef NIOS_MUL_SEQ_HI_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hi_q, hi_d;
  logic          req_ready_q, req_ready_d;
  logic          cell_en_q, cell_en_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [W-1:0]  src1_q, src1_d, src2_q, src2_d;
  logic [W-1:0]  sp1_q, sp1_d, sp2_q, sp2_d, sp3_q, sp3_d;
  logic [W-1:0]  rsp_data_q, rsp_data_d;
  logic [W-1:0]  lo_w, hi_w;

  nios_mul_combine u_combine (
    .p1(cell_p1), .p2(cell_p2), .p3(cell_p3),
    .sp1(sp1_q), .sp2(sp2_q), .sp3(sp3_q),
    .lo(lo_w), .hi(hi_w)
  );

  // next-state and registered-output logic for the issue/wait/respond sequence
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    req_ready_d = 1'b0;
    cell_en_d   = 1'b0;
    rsp_valid_d = rsp_valid_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    sp1_d       = sp1_q;
    sp2_d       = sp2_q;
    sp3_d       = sp3_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d   = ISSUE_LO;
          cell_en_d = 1'b1;
          src1_d    = req_src1;
          src2_d    = req_src2;
          hi_d      = req_hi;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ISSUE_LO: begin
        state_d = WAIT_LO;
        cnt_d   = CNT_INIT;
      end
      WAIT_LO: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (HI_EN && hi_q) begin
          state_d   = ISSUE_HI;
          cell_en_d = 1'b1;
          sp1_d     = cell_p1;
          sp2_d     = cell_p2;
          sp3_d     = cell_p3;
          src1_d    = {{HW{1'b0}}, src1_q[W-1:HW]};
          src2_d    = {{HW{1'b0}}, src2_q[W-1:HW]};
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = lo_w;
        end
      end
      ISSUE_HI: begin
        state_d = WAIT_HI;
        cnt_d   = CNT_INIT;
      end
      WAIT_HI: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = hi_w;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= 1'b0;
      req_ready_q <= 1'b0;
      cell_en_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      src1_q      <= '0;
      src2_q      <= '0;
      sp1_q       <= '0;
      sp2_q       <= '0;
      sp3_q       <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      req_ready_q <= req_ready_d;
      cell_en_q   <= cell_en_d;
      rsp_valid_q <= rsp_valid_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      sp1_q       <= sp1_d;
      sp2_q       <= sp2_d;
      sp3_q       <= sp3_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready = req_ready_q;
  assign cell_en   = cell_en_q;
  assign cell_src1 = src1_q;
  assign cell_src2 = src2_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_nios_mul_seq.sv
// tb_nios_mul_seq: random and directed checks of nios_mul_seq against a 64-bit product model
module tb_nios_mul_seq;
  localparam int LAT = 1;
`ifdef NIOS_MUL_SEQ_HI_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_src1 = '0;
  logic [31:0] req_src2 = '0;
  logic        req_hi = 1'b0;
  logic [31:0] cell_src1, cell_src2;
  logic        cell_en;
  logic [31:0] cell_p1, cell_p2, cell_p3;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  int          total = 0;
  int          bad = 0;
  logic [31:0] cp [LAT][3];

  nios_mul_seq #(.CELL_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2), .req_hi(req_hi),
    .cell_src1(cell_src1), .cell_src2(cell_src2), .cell_en(cell_en),
    .cell_p1(cell_p1), .cell_p2(cell_p2), .cell_p3(cell_p3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // external 16x16 cell: products registered on enable, then LAT-1 further stages
  always @(posedge clk) begin
    if (cell_en) begin
      cp[0][0] <= 32'(cell_src1[15:0]) * 32'(cell_src2[15:0]);
      cp[0][1] <= 32'(cell_src1[15:0]) * 32'(cell_src2[31:16]);
      cp[0][2] <= 32'(cell_src1[31:16]) * 32'(cell_src2[15:0]);
    end
    for (int i = 1; i < LAT; i++) cp[i] <= cp[i-1];
  end
  assign cell_p1 = cp[LAT-1][0];
  assign cell_p2 = cp[LAT-1][1];
  assign cell_p3 = cp[LAT-1][2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic hi, input int stall, input string tag);
    logic [63:0] prod;
    logic [31:0] exp, held;
    bit          do_hi;
    int          n, ens;
    prod  = 64'(a) * 64'(b);
    do_hi = hi && HI_EN;
    exp   = do_hi ? prod[63:32] : prod[31:0];
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_src1  = a;
    req_src2  = b;
    req_hi    = hi;
    @(posedge clk);
    #1;
    req_valid = (stall > 0);
    req_src1  = $urandom;
    req_src2  = $urandom;
    req_hi    = 1'($urandom);
    n = 0;
    ens = 0;
    do begin
      @(negedge clk);
      n++;
      ens += int'(cell_en);
    end while (!rsp_valid && n < 60);
    check({tag, "_lat"}, 32'(n), do_hi ? 32'(3 + 2 * LAT) : 32'(2 + LAT));
    check({tag, "_data"}, rsp_data, exp);
    held = rsp_data;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      ens += int'(cell_en);
      check({tag, "_hold_v"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_d"}, rsp_data, exp);
      check({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
    end
    check({tag, "_en"}, 32'(ens), do_hi ? 32'd2 : 32'd1);
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_idle_rdy"}, 32'(req_ready), 32'd1);
    check({tag, "_idle_v"}, 32'(rsp_valid), 32'd0);
    check({tag, "_keep_d"}, rsp_data, held);
  endtask

  initial begin
    int nv;
    #2;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data", rsp_data, 32'd0);
    check("rst_en", 32'(cell_en), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    run_op(32'd3, 32'd5, 1'b0, 0, "m3x5");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, "mff_lo");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, "mff_hi");
    run_op(32'h00010000, 32'h00010000, 1'b0, 0, "m1616_lo");
    run_op(32'h00010000, 32'h00010000, 1'b1, 0, "m1616_hi");
    run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 5, "stall");

    req_valid = 1'b1;
    req_src1  = 32'd9;
    req_src2  = 32'd11;
    req_hi    = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_data", rsp_data, 32'd0);
    check("mid_rst_en", 32'(cell_en), 32'd0);
    check("mid_rst_src1", cell_src1, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(req_ready), 32'd1);
    nv = 0;
    repeat (4) begin
      @(negedge clk);
      nv += int'(rsp_valid);
    end
    check("rel_no_rsp", 32'(nv), 32'd0);
    run_op(32'd7, 32'd6, 1'b0, 0, "m7x6");

    for (int k = 0; k < 24; k++)
      run_op($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)), "rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
